// File: rtl/ps2_pkg.sv
// Shared constants, state types and key lookup for the PS/2 keyboard decoder.
package ps2_pkg;

  // Host commands and keyboard responses
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
  localparam logic [7:0] RSP_ECHO     = 8'hEE;
  localparam logic [7:0] RSP_ERR      = 8'h00;

  // Scan Code Set 2 prefixes
  localparam logic [7:0] PFX_EXT      = 8'hE0;
  localparam logic [7:0] PFX_PAUSE    = 8'hE1;
  localparam logic [7:0] PFX_BREAK    = 8'hF0;

  // Key codes of interest
  localparam logic [7:0] KEY_LEFT     = 8'h6B;
  localparam logic [7:0] KEY_RIGHT    = 8'h74;
  localparam logic [7:0] KEY_DOWN     = 8'h72;
  localparam logic [7:0] KEY_ROTATE   = 8'h75;
  localparam logic [7:0] KEY_DROP     = 8'h29;
  localparam logic [7:0] FAKE_SHIFT_L = 8'h12;
  localparam logic [7:0] FAKE_SHIFT_R = 8'h59;

  // key_state bit positions
  localparam int unsigned KS_LEFT   = 0;
  localparam int unsigned KS_RIGHT  = 1;
  localparam int unsigned KS_DOWN   = 2;
  localparam int unsigned KS_ROTATE = 3;
  localparam int unsigned KS_DROP   = 4;

  // Bytes remaining in the Pause sequence after the leading E1
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {I_SEND, I_TXWAIT, I_ACK, I_BAT, RUN} init_state_t;
  typedef enum logic [2:0] {D_IDLE, D_E0, D_F0, D_E0F0, D_E1SKIP} dec_state_t;

  // One-hot key_state mask for a decoded key, zero if not a tracked key
  function automatic logic [4:0] key_mask(input logic ext, input logic [7:0] code);
    key_mask = '0;
    if (ext) begin
      case (code)
        KEY_LEFT:   key_mask[KS_LEFT]   = 1'b1;
        KEY_RIGHT:  key_mask[KS_RIGHT]  = 1'b1;
        KEY_DOWN:   key_mask[KS_DOWN]   = 1'b1;
        KEY_ROTATE: key_mask[KS_ROTATE] = 1'b1;
        default:    key_mask = '0;
      endcase
    end else if (code == KEY_DROP) begin
      key_mask[KS_DROP] = 1'b1;
    end
  endfunction

  // Keyboard responses that carry no key information when seen unprefixed
  function automatic logic is_ignored(input logic [7:0] code);
    case (code)
      RSP_ACK, RSP_BAT_OK, RSP_ECHO, RSP_ERR, CMD_RESET: is_ignored = 1'b1;
      default:                                           is_ignored = 1'b0;
    endcase
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] code);
    is_fake_shift = (code == FAKE_SHIFT_L) || (code == FAKE_SHIFT_R);
  endfunction

endpackage

// File: rtl/ps2_kbd_init.sv
// Keyboard reset handshake: send FF, await ACK then BAT, retry on timeout/BAT failure.
module ps2_kbd_init
  import ps2_pkg::*;
#(
  parameter int                   TIMEOUT_W    = 26,
  parameter logic [TIMEOUT_W-1:0] INIT_TIMEOUT = 26'd50_000_000,
  parameter int                   MAX_RETRY    = 3,
  parameter bit                   SKIP_INIT    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  input  logic       tx_done,
  output logic       wr_stb,
  output logic [7:0] wr_data,
  output logic       init_done,
  output logic       init_ok,
  output logic       run_en
);

  localparam int unsigned          RW      = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]        MAX_R   = RW'(MAX_RETRY);
  localparam logic [TIMEOUT_W-1:0] TO_LAST = INIT_TIMEOUT - 1'b1;

  init_state_t          state_q, state_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [RW-1:0]        retry_q, retry_d, retry_inc;
  logic                 wr_stb_q, wr_stb_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 init_ok_q, init_ok_d;
  logic                 do_retry;

  // Next-state, timer and retry bookkeeping
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    wr_stb_d  = 1'b0;
    wr_data_d = wr_data_q;
    init_ok_d = init_ok_q;
    do_retry  = 1'b0;
    retry_inc = retry_q + 1'b1;

    case (state_q)
      I_SEND: begin
        timer_d = '0;
        if (tx_ready) begin
          wr_stb_d  = 1'b1;
          wr_data_d = CMD_RESET;
          state_d   = I_TXWAIT;
        end
      end
      I_TXWAIT: begin
        timer_d = timer_q + 1'b1;
        if (tx_done) begin
          timer_d = '0;
          state_d = I_ACK;
        end else if (timer_q == TO_LAST) begin
          do_retry = 1'b1;
        end
      end
      I_ACK: begin
        timer_d = timer_q + 1'b1;
        if (rx_valid && rx_data == RSP_ACK) begin
          timer_d = '0;
          state_d = I_BAT;
        end else if (timer_q == TO_LAST) begin
          do_retry = 1'b1;
        end
      end
      I_BAT: begin
        timer_d = timer_q + 1'b1;
        if (rx_valid && rx_data == RSP_BAT_OK) begin
          init_ok_d = 1'b1;
          state_d   = RUN;
        end else if ((rx_valid && rx_data == RSP_BAT_FAIL) || timer_q == TO_LAST) begin
          do_retry = 1'b1;
        end
      end
      RUN: begin
        timer_d = timer_q;
      end
      default: state_d = I_SEND;
    endcase

    if (do_retry) begin
      retry_d = retry_inc;
      timer_d = '0;
      if (retry_inc < MAX_R) state_d = I_SEND;
      else                   state_d = RUN;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (SKIP_INIT) state_q <= RUN;
      else           state_q <= I_SEND;
      timer_q   <= '0;
      retry_q   <= '0;
      wr_stb_q  <= 1'b0;
      wr_data_q <= '0;
      init_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      wr_stb_q  <= wr_stb_d;
      wr_data_q <= wr_data_d;
      init_ok_q <= init_ok_d;
    end
  end

  assign wr_stb    = wr_stb_q;
  assign wr_data   = wr_data_q;
  assign init_ok   = init_ok_q;
  assign init_done = (state_q == RUN);
  assign run_en    = (state_q == RUN);

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard front end: init handshake plus Set 2 scan code decoding into key events.
module ps2_kbd_decoder
  import ps2_pkg::*;
#(
  parameter int                   TIMEOUT_W    = 26,
  parameter logic [TIMEOUT_W-1:0] INIT_TIMEOUT = 26'd50_000_000,
  parameter int                   MAX_RETRY    = 3,
  parameter bit                   SKIP_INIT    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_rddata_valid,
  input  logic [7:0] ps2_rd_data,
  input  logic       ps2_tx_ready,
  input  logic       ps2_tx_done,
  output logic       ps2_wr_stb,
  output logic [7:0] ps2_wr_data,
  output logic       init_done,
  output logic       init_ok,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [4:0] key_state
);

  logic run_en;

  ps2_kbd_init #(
    .TIMEOUT_W   (TIMEOUT_W),
    .INIT_TIMEOUT(INIT_TIMEOUT),
    .MAX_RETRY   (MAX_RETRY),
    .SKIP_INIT   (SKIP_INIT)
  ) u_init (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (ps2_rddata_valid),
    .rx_data  (ps2_rd_data),
    .tx_ready (ps2_tx_ready),
    .tx_done  (ps2_tx_done),
    .wr_stb   (ps2_wr_stb),
    .wr_data  (ps2_wr_data),
    .init_done(init_done),
    .init_ok  (init_ok),
    .run_en   (run_en)
  );

  dec_state_t dstate_q, dstate_d;
  logic [2:0] skip_q, skip_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_break_q, key_break_d;
  logic [4:0] key_state_q, key_state_d;
  logic       emit, e_ext, e_brk;
  logic [4:0] mask;

  // Prefix tracking and event generation, one received byte per strobe
  always_comb begin
    dstate_d    = dstate_q;
    skip_d      = skip_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    key_state_d = key_state_q;
    emit        = 1'b0;
    e_ext       = 1'b0;
    e_brk       = 1'b0;
    mask        = '0;

    if (run_en && ps2_rddata_valid) begin
      case (dstate_q)
        D_IDLE: begin
          if (ps2_rd_data == PFX_EXT) begin
            dstate_d = D_E0;
          end else if (ps2_rd_data == PFX_BREAK) begin
            dstate_d = D_F0;
          end else if (ps2_rd_data == PFX_PAUSE) begin
            skip_d   = PAUSE_SKIP;
            dstate_d = D_E1SKIP;
          end else if (!is_ignored(ps2_rd_data)) begin
            emit = 1'b1;
          end
        end
        D_E0: begin
          if (ps2_rd_data == PFX_BREAK) begin
            dstate_d = D_E0F0;
          end else if (is_fake_shift(ps2_rd_data)) begin
            dstate_d = D_IDLE;
          end else if (ps2_rd_data != PFX_EXT) begin
            emit     = 1'b1;
            e_ext    = 1'b1;
            dstate_d = D_IDLE;
          end
        end
        D_F0: begin
          emit     = 1'b1;
          e_brk    = 1'b1;
          dstate_d = D_IDLE;
        end
        D_E0F0: begin
          emit     = !is_fake_shift(ps2_rd_data);
          e_ext    = 1'b1;
          e_brk    = 1'b1;
          dstate_d = D_IDLE;
        end
        D_E1SKIP: begin
          skip_d = skip_q - 1'b1;
          if (skip_q == 3'd1) dstate_d = D_IDLE;
        end
        default: dstate_d = D_IDLE;
      endcase
    end

    if (emit) begin
      key_valid_d = 1'b1;
      key_code_d  = ps2_rd_data;
      key_ext_d   = e_ext;
      key_break_d = e_brk;
      mask        = key_mask(e_ext, ps2_rd_data);
      key_state_d = e_brk ? (key_state_q & ~mask) : (key_state_q | mask);
    end
  end

  // Decoder state and registered event outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dstate_q    <= D_IDLE;
      skip_q      <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      key_state_q <= '0;
    end else begin
      dstate_q    <= dstate_d;
      skip_q      <= skip_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      key_state_q <= key_state_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_break = key_break_q;
  assign key_state = key_state_q;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Scoreboard bench for ps2_kbd_decoder with a prefix-flag reference model.
module tb_ps2_kbd_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_rddata_valid = 1'b0;
  logic [7:0] ps2_rd_data = '0;
  logic       ps2_tx_ready = 1'b0;
  logic       ps2_tx_done = 1'b0;
  logic       ps2_wr_stb;
  logic [7:0] ps2_wr_data;
  logic       init_done, init_ok, key_valid, key_ext, key_break;
  logic [7:0] key_code;
  logic [4:0] key_state;

  ps2_kbd_decoder #(
    .TIMEOUT_W   (26),
    .INIT_TIMEOUT(26'd100),
    .MAX_RETRY   (3),
    .SKIP_INIT   (1'b0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ps2_rddata_valid(ps2_rddata_valid),
    .ps2_rd_data     (ps2_rd_data),
    .ps2_tx_ready    (ps2_tx_ready),
    .ps2_tx_done     (ps2_tx_done),
    .ps2_wr_stb      (ps2_wr_stb),
    .ps2_wr_data     (ps2_wr_data),
    .init_done       (init_done),
    .init_ok         (init_ok),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .key_ext         (key_ext),
    .key_break       (key_break),
    .key_state       (key_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [4:0] st;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  stb_cnt = 0;
  int  stb_cyc[$];

  // Reference model: pending prefix flags plus a Pause skip count
  logic       m_ext = 1'b0, m_brk = 1'b0;
  int         m_skip = 0;
  logic [4:0] m_state = '0;

  function automatic int key_bit(input logic ext, input logic [7:0] code);
    logic [8:0] tracked [5];
    tracked = '{9'h16B, 9'h174, 9'h172, 9'h175, 9'h029};
    key_bit = -1;
    for (int i = 0; i < 5; i++)
      if (tracked[i] == {ext, code}) key_bit = i;
  endfunction

  function automatic void emit(input logic [7:0] code, input logic ext, input logic brk);
    ev_t e;
    int  b;
    b = key_bit(ext, code);
    if (b >= 0) m_state[b] = !brk;
    e.code = code; e.ext = ext; e.brk = brk; e.st = m_state;
    exp_q.push_back(e);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic fake;
    fake = (b == 8'h12) || (b == 8'h59);
    if (m_skip > 0) begin
      m_skip--;
    end else if (!m_ext && !m_brk) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE1) m_skip = 7;
      else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'h00, 8'hFF})) emit(b, 1'b0, 1'b0);
    end else if (m_ext && !m_brk) begin
      if (b == 8'hF0) m_brk = 1'b1;
      else if (fake) m_ext = 1'b0;
      else if (b != 8'hE0) begin emit(b, 1'b1, 1'b0); m_ext = 1'b0; end
    end else begin
      if (!(m_ext && fake)) emit(b, m_ext, 1'b1);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0; m_state = '0;
    exp_q.delete();
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: pops an expectation for every key event, logs every transmit request
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) begin
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL event: unexpected key_valid code=%02h ext=%0b brk=%0b", key_code, key_ext, key_break);
        end else begin
          e = exp_q.pop_front();
          if (!init_done || key_code !== e.code || key_ext !== e.ext ||
              key_break !== e.brk || key_state !== e.st) begin
            miscompares++;
            $display("FAIL event: got code=%02h ext=%0b brk=%0b st=%05b done=%0b, want code=%02h ext=%0b brk=%0b st=%05b done=1",
                     key_code, key_ext, key_break, key_state, init_done, e.code, e.ext, e.brk, e.st);
          end
        end
      end
      if (ps2_wr_stb) begin
        stb_cnt++;
        stb_cyc.push_back(cyc);
        vectors++;
        if (ps2_wr_data !== 8'hFF) begin
          miscompares++;
          $display("FAIL wr_data: got %02h want ff", ps2_wr_data);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, " wr_stb"},    32'(ps2_wr_stb), 0);
    check({tag, " wr_data"},   32'(ps2_wr_data), 0);
    check({tag, " init_done"}, 32'(init_done), 0);
    check({tag, " init_ok"},   32'(init_ok), 0);
    check({tag, " key_valid"}, 32'(key_valid), 0);
    check({tag, " key_code"},  32'(key_code), 0);
    check({tag, " key_ext"},   32'(key_ext), 0);
    check({tag, " key_break"}, 32'(key_break), 0);
    check({tag, " key_state"}, 32'(key_state), 0);
  endtask

  // Byte drive helpers; called at posedge+1
  task automatic send_raw(input logic [7:0] b, input int gap);
    ps2_rddata_valid = 1'b1;
    ps2_rd_data      = b;
    @(posedge clk); #1;
    ps2_rddata_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    model_byte(b);
    send_raw(b, gap);
  endtask

  task automatic send_seq(input logic [7:0] seq[$]);
    foreach (seq[i]) send_byte(seq[i], 1);
  endtask

  task automatic wait_stb(input int target, input string nm);
    int t = 0;
    while (stb_cnt < target && t < 500) begin @(posedge clk); #1; t++; end
    if (stb_cnt < target) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: wr_stb count %0d want %0d within 500 cycles", nm, stb_cnt, target);
    end
  endtask

  task automatic drain(input string nm);
    repeat (4) begin @(posedge clk); #1; end
    check({nm, " pending events"}, 32'(exp_q.size()), 0);
  endtask

  task automatic do_init(input string nm);
    int base;
    base = stb_cnt;
    ps2_tx_ready = 1'b1;
    wait_stb(base + 1, {nm, " first send"});
    @(posedge clk); #1;
    ps2_tx_done = 1'b1;
    @(posedge clk); #1;
    ps2_tx_done = 1'b0;
    send_raw(8'hFA, 2);
    send_raw(8'hAA, 2);
    repeat (3) begin @(posedge clk); #1; end
    check({nm, " init_done"}, 32'(init_done), 1);
    check({nm, " init_ok"},   32'(init_ok), 1);
    check({nm, " send count"}, 32'(stb_cnt - base), 1);
  endtask

  initial begin
    logic [7:0] pool [16];
    int base, idx, guard;
    pool = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h6B, 8'h74, 8'h72,
             8'h75, 8'h29, 8'h1C, 8'hFA, 8'hAA, 8'hEE, 8'h00, 8'hFF};

    // Reset values
    repeat (3) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Normal init handshake
    do_init("init");

    // Extended make/break of left
    send_seq('{8'hE0, 8'h6B});
    drain("left make");
    check("left make state", 32'(key_state), 32'h01);
    send_seq('{8'hE0, 8'hF0, 8'h6B});
    drain("left break");
    check("left break state", 32'(key_state), 32'h00);

    // Drop with typematic repeat then release
    send_seq('{8'h29, 8'h29, 8'hF0, 8'h29});
    drain("drop");
    check("drop state", 32'(key_state), 32'h00);

    // Pause sequence swallowed, decoder back in idle
    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C, 8'h6B});
    drain("pause");

    // Randomised stream, back-to-back strobes allowed
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), $urandom_range(0, 2));
      else send_byte(pool[$urandom_range(0, 15)], $urandom_range(0, 2));
    end
    guard = 0;
    while ((m_ext || m_brk || m_skip > 0) && guard < 20) begin
      send_byte(8'h1C, 0);
      guard++;
    end
    drain("random");
    check("random state", 32'(key_state), 32'(m_state));

    // No keyboard response: retries then give up
    rst = 1'b1;
    model_reset();
    ps2_tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    base = stb_cnt;
    idx  = stb_cyc.size();
    guard = 0;
    while (!init_done && guard < 2000) begin @(posedge clk); #1; guard++; end
    check("timeout init_done", 32'(init_done), 1);
    check("timeout init_ok", 32'(init_ok), 0);
    check("timeout send count", 32'(stb_cnt - base), 3);
    if (stb_cyc.size() >= idx + 3) begin
      for (int k = 0; k < 2; k++) begin
        int gap_c;
        gap_c = stb_cyc[idx + k + 1] - stb_cyc[idx + k];
        check($sformatf("timeout gap%0d in range", k), 32'(gap_c >= 95 && gap_c <= 110), 1);
      end
    end
    repeat (300) @(posedge clk);
    #1;
    check("no send after give-up", 32'(stb_cnt - base), 3);
    check("timeout pending events", 32'(exp_q.size()), 0);

    // Reset aborts a partial E0 F0 sequence
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    do_init("reinit");
    send_seq('{8'hE0, 8'h12, 8'hE0, 8'h75});
    drain("rotate");
    check("rotate state", 32'(key_state), 32'h08);
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    rst = 1'b1;
    model_reset();
    check_reset_outputs("mid reset");
    @(posedge clk); #1;
    rst = 1'b0;
    base = stb_cnt;
    wait_stb(base + 1, "restart send");
    repeat (4) @(posedge clk);
    #1;
    check("restart send count", 32'(stb_cnt - base), 1);
    check("restart no event", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_decoder.md
Name: ps2_kbd_decoder

Overview:
- Downstream consumer of the PS/2 host rx/tx block. It also drives that block's transmit side.
- After reset it initialises the keyboard: sends 0xFF, expects ACK 0xFA, then BAT 0xAA.
- It then decodes Scan Code Set 2 bytes into press/release events, handling the E0, F0 and E1 prefixes.
- It keeps a held-state vector of the five Tetris control keys for the game controller.

Parameters:
- TIMEOUT_W, 26: width of the init timeout counter.
- INIT_TIMEOUT, 26'd50_000_000: cycles to wait for each init response before retrying.
- MAX_RETRY, 3: number of 0xFF transmissions before giving up.
- SKIP_INIT, 0: when 1, reset goes straight to RUN with init_done=1 (simulation use).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ps2_rddata_valid  in  1  one-cycle strobe; received byte is valid
- ps2_rd_data  in  8  received byte
- ps2_tx_ready  in  1  transmitter idle, can accept a byte
- ps2_tx_done  in  1  one-cycle strobe; transmission finished
- ps2_wr_stb  out  1  one-cycle request to transmit
- ps2_wr_data  out  8  byte to transmit
- init_done  out  1  level; init finished (pass or fail)
- init_ok  out  1  level; BAT 0xAA was received
- key_valid  out  1  one-cycle key event strobe
- key_code  out  8  scan code of the event, prefixes stripped
- key_ext  out  1  event carried the E0 prefix
- key_break  out  1  event is a release (F0 seen)
- key_state  out  5  held keys: {drop, rotate, down, right, left}

Behaviour:
- Reset values: all outputs 0, both FSMs at their initial state, retry count 0, timeout counter 0.
- Reset mid-operation aborts any sequence in progress. No partial event is emitted.

Init FSM (states I_SEND, I_TXWAIT, I_ACK, I_BAT, RUN):
- I_SEND: wait for ps2_tx_ready=1. Then assert ps2_wr_stb for exactly 1 cycle with ps2_wr_data=0xFF, and go to I_TXWAIT.
- I_TXWAIT: on ps2_tx_done, clear the timer and go to I_ACK.
- I_ACK:
  - rx 0xFA: clear the timer, go to I_BAT.
  - Any other byte is ignored.
- I_BAT:
  - rx 0xAA: set init_ok=1, go to RUN.
  - rx 0xFC: BAT failure, treated as a retry.
- Timeout: in I_TXWAIT, I_ACK and I_BAT the timer counts up. When it reaches INIT_TIMEOUT-1 (or on 0xFC in I_BAT), retry:
  - increment the retry count;
  - go to I_SEND if the count is below MAX_RETRY;
  - otherwise go to RUN with init_ok=0.
- RUN: init_done=1. init_done and init_ok hold until reset.
- ps2_wr_data holds 0xFF after the first send.
- key_valid never asserts before RUN.

Decode FSM (active in RUN only; states D_IDLE, D_E0, D_F0, D_E0F0, D_E1SKIP):
- From D_IDLE:
  - E0 goes to D_E0; F0 goes to D_F0; E1 loads a skip counter with 7 and goes to D_E1SKIP.
  - 0xFA, 0xAA, 0xEE, 0x00 and 0xFF are ignored and the state stays D_IDLE.
  - Any other byte emits a make event with ext=0.
- From D_E0:
  - F0 goes to D_E0F0.
  - 0x12 and 0x59 (fake shifts) are dropped; go to D_IDLE.
  - E0 stays in D_E0.
  - Any other byte emits make with ext=1, then D_IDLE.
- From D_F0: any byte emits break with ext=0, then D_IDLE.
- From D_E0F0: 0x12 and 0x59 are dropped; any other byte emits break with ext=1; then D_IDLE.
- D_E1SKIP: decrement on each byte. Return to D_IDLE when the counter reaches 0. No event is emitted (Pause is ignored).
- Event timing:
  - key_valid asserts the cycle after the ps2_rddata_valid that completes the code.
  - key_code, key_ext and key_break are registered with it and hold until the next event.
  - One byte is processed per strobe. A strobe on back-to-back cycles is handled without loss.
- key_state:
  - Updated in the same cycle as key_valid: set on make, clear on break.
  - Mapping: left = E0 6B, right = E0 74, down = E0 72, rotate = E0 75, drop = 29 (ext=0).
  - Typematic repeat makes leave a set bit set; they still emit key_valid.
  - An unmatched break clears a bit that is already 0 (no-op).

Decomposition:
- Shared package ps2_pkg: command/response constants (FF, FA, AA, FC, EE, E0, E1, F0), key code constants, and the key_state bit index constants.
- Sub-module ps2_kbd_init: the init FSM, timer and retry counter. It outputs the tx handshake, init_done and init_ok, and a run enable to the decode FSM in the top.

Test Plan:
- Reset, tx_ready=1 -> one ps2_wr_stb with data 0xFF. Then tx_done, rx FA, rx AA -> init_done=1, init_ok=1, no key_valid.
- No response, INIT_TIMEOUT=100, MAX_RETRY=3 -> exactly 3 wr_stb pulses about 100 cycles apart, then init_done=1, init_ok=0.
- Bytes E0 6B -> key_valid, code 6B, ext=1, break=0, key_state=00001. Then E0 F0 6B -> break=1, key_state=00000.
- Bytes 29, 29, F0 29 -> two make events plus one break; key_state[4] goes 1,1,0.
- Bytes E1 14 77 E1 F0 14 F0 77, then 1C -> one event only (code 1C, ext=0); the state is D_IDLE afterwards.
- Bytes E0 12 E0 75, then rst asserted in the middle of E0 F0 -> one rotate make. After reset all outputs are 0 and init restarts (wr_stb 0xFF).
